alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  ID/EX pipeline register that directly feeds the ALU. Captures register-file
//  operands, the immediate and decoded control, then resolves EX/MEM and MEM/WB
//  forwarding. Drives registered alu_in0/alu_in1/alu_ctrl and a valid/ready
//  handshake, so the core can stall and flush between decode and execute.
// PARAMETERS
//  DATA_W   32  operand/result width
//  REG_AW   5   register address width
//  CTRL_W   4   ALU control width
// PORTS
//  clk           in   1       clock, rising edge
//  rst_n         in   1       asynchronous reset, active-low
//  in_valid      in   1       decode has an instruction
//  in_ready      out  1       stage accepts this cycle
//  rs_addr       in   REG_AW  source 0 register index
//  rt_addr       in   REG_AW  source 1 register index
//  rs_data       in   DATA_W  regfile read data, source 0
//  rt_data       in   DATA_W  regfile read data, source 1
//  imm           in   DATA_W  sign-extended immediate
//  alu_src       in   1       1: alu_in1 = imm; 0: alu_in1 = rt operand
//  alu_ctrl_in   in   CTRL_W  ALU operation code
//  rd_addr_in    in   REG_AW  destination index
//  reg_write_in  in   1       destination write enable
//  exmem_wr      in   1       EX/MEM result will be written
//  exmem_rd      in   REG_AW  EX/MEM destination
//  exmem_data    in   DATA_W  EX/MEM ALU result
//  memwb_wr      in   1       MEM/WB result will be written
//  memwb_rd      in   REG_AW  MEM/WB destination
//  memwb_data    in   DATA_W  MEM/WB writeback value
//  flush         in   1       squash the held and incoming instruction
//  out_valid     out  1       ALU operands valid
//  out_ready     in   1       execute consumes this cycle
//  alu_in0       out  DATA_W  ALU operand 0
//  alu_in1       out  DATA_W  ALU operand 1
//  alu_ctrl      out  CTRL_W  ALU operation code
//  rd_addr       out  REG_AW  destination index
//  reg_write     out  1       destination write enable, forced 0 when !out_valid
//  store_data    out  DATA_W  forwarded rt operand, for stores
// BEHAVIOUR
//  - Reset (rst_n=0, async): out_valid=0 and every data/control output=0.
//  - in_ready = !out_valid | out_ready (combinational). Capture on in_valid & in_ready.
//  - Latency 1: a value captured at edge N is visible at outputs after edge N.
//  - Forward select per source s: EX/MEM if exmem_wr & exmem_rd==s & s!=0;
//    else MEM/WB if memwb_wr & memwb_rd==s & s!=0; else regfile data.
//    EX/MEM has priority when both match. Register 0 is never forwarded.
//  - Hold: while out_valid & !out_ready, outputs stay stable except the stored rs/rt
//    operands. These re-apply the forward select each cycle against the stored
//    addresses, so a hold never leaves a stale operand. alu_in1 tracks the rt
//    operand only when stored alu_src=0. store_data always tracks it.
//  - Flush: out_valid=0 at the next edge. Flush beats a simultaneous capture:
//    the input is dropped. Data registers may keep old values, but reg_write
//    reads 0.
//  - Consume + capture in the same cycle: the new instruction replaces the old
//    one with no bubble.
//  - Reset mid-hold: the instruction is lost and out_valid=0 right away.
//  - No arithmetic inside. Widths pass through unchanged, signed view is the
//    consumer's.
// STRUCTURE
//  - cpu_pkg: DATA_W/REG_AW/CTRL_W, ALU op constants AND=4'b0000 OR=4'b0001
//    ADD=4'b0010 SUB=4'b0110 SLT=4'b0111 NOR=4'b1100.
//  - Sub-module operand_fwd_mux (combinational priority select), instantiated
//    twice at capture and twice on the hold path, or shared via an address mux.
// TESTING
//  1 Reset: rst_n=0 mid-run -> out_valid=0, alu_in0=0, reg_write=0 immediately.
//  2 No hazard: rs=3 rs_data=5, rt=4 rt_data=7, ADD, alu_src=0 -> next cycle
//    alu_in0=5 alu_in1=7 ctrl=0010.
//  3 Double hazard: rs=2, exmem_rd=2 data=11, memwb_rd=2 data=22 -> alu_in0=11;
//    rs=0 with exmem_rd=0 -> regfile value.
//  4 Hold: out_ready=0 for 3 cycles, memwb_rd=rt data=9 in cycle 2 -> alu_in1=9,
//    alu_in0 and ctrl unchanged. With alu_src=1: alu_in1=imm, store_data=9.
//  5 Flush with in_valid=1 -> out_valid=0 next cycle, the following capture is normal.
//  6 Back-to-back: in_valid=out_ready=1 for 4 cycles -> 4 outputs on consecutive
//    cycles, in_ready held 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core widths and ALU operation codes.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/operand_fwd_mux.sv
// Priority forwarding select for one source operand: EX/MEM, then MEM/WB, then base data.
module operand_fwd_mux
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] base_data,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] fwd_data_c
);

  logic src_nonzero;
  logic hit_exmem;
  logic hit_memwb;

  assign src_nonzero = (src_addr != REG_AW'(0));
  assign hit_exmem   = exmem_wr && (exmem_rd == src_addr) && src_nonzero;
  assign hit_memwb   = memwb_wr && (memwb_rd == src_addr) && src_nonzero;

  always_comb begin
    fwd_data_c = base_data;
    if (hit_exmem) begin
      fwd_data_c = exmem_data;
    end else if (hit_memwb) begin
      fwd_data_c = memwb_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register feeding the ALU, with operand forwarding that keeps refreshing
// while the stage is stalled.
module alu_operand_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic [CTRL_W-1:0] alu_ctrl_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  input  logic              reg_write_in,
  input  logic              exmem_wr,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [REG_AW-1:0] rd_addr,
  output logic              reg_write,
  output logic [DATA_W-1:0] store_data
);

  logic              hold;
  logic              capture;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic              alu_src_q;
  logic [REG_AW-1:0] src0_addr;
  logic [REG_AW-1:0] src1_addr;
  logic [DATA_W-1:0] src0_base;
  logic [DATA_W-1:0] src1_base;
  logic [DATA_W-1:0] fwd0;
  logic [DATA_W-1:0] fwd1;

  assign in_ready = !out_valid || out_ready;
  assign hold     = out_valid && !out_ready;
  assign capture  = in_valid && in_ready && !flush;

  // One mux pair serves both capture and hold: a stall re-forwards the stored operands.
  assign src0_addr = hold ? rs_q       : rs_addr;
  assign src1_addr = hold ? rt_q       : rt_addr;
  assign src0_base = hold ? alu_in0    : rs_data;
  assign src1_base = hold ? store_data : rt_data;

  operand_fwd_mux u_fwd_rs (
    .src_addr   (src0_addr),
    .base_data  (src0_base),
    .exmem_wr   (exmem_wr),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_wr   (memwb_wr),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .fwd_data_c (fwd0)
  );

  operand_fwd_mux u_fwd_rt (
    .src_addr   (src1_addr),
    .base_data  (src1_base),
    .exmem_wr   (exmem_wr),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_wr   (memwb_wr),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .fwd_data_c (fwd1)
  );

  // Pipeline register; flush wins over capture and hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      reg_write  <= 1'b0;
      alu_in0    <= '0;
      alu_in1    <= '0;
      store_data <= '0;
      alu_ctrl   <= '0;
      rd_addr    <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      alu_src_q  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
    end else if (capture) begin
      out_valid  <= 1'b1;
      reg_write  <= reg_write_in;
      alu_in0    <= fwd0;
      alu_in1    <= alu_src ? imm : fwd1;
      store_data <= fwd1;
      alu_ctrl   <= alu_ctrl_in;
      rd_addr    <= rd_addr_in;
      rs_q       <= rs_addr;
      rt_q       <= rt_addr;
      alu_src_q  <= alu_src;
    end else if (hold) begin
      alu_in0    <= fwd0;
      store_data <= fwd1;
      if (!alu_src_q) begin
        alu_in1 <= fwd1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;
  import cpu_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] imm;
  logic              alu_src;
  logic [CTRL_W-1:0] alu_ctrl_in;
  logic [REG_AW-1:0] rd_addr_in;
  logic              reg_write_in;
  logic              exmem_wr;
  logic [REG_AW-1:0] exmem_rd;
  logic [DATA_W-1:0] exmem_data;
  logic              memwb_wr;
  logic [REG_AW-1:0] memwb_rd;
  logic [DATA_W-1:0] memwb_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_in0;
  logic [DATA_W-1:0] alu_in1;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [REG_AW-1:0] rd_addr;
  logic              reg_write;
  logic [DATA_W-1:0] store_data;

  int total = 0;
  int bad   = 0;

  alu_operand_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .imm          (imm),
    .alu_src      (alu_src),
    .alu_ctrl_in  (alu_ctrl_in),
    .rd_addr_in   (rd_addr_in),
    .reg_write_in (reg_write_in),
    .exmem_wr     (exmem_wr),
    .exmem_rd     (exmem_rd),
    .exmem_data   (exmem_data),
    .memwb_wr     (memwb_wr),
    .memwb_rd     (memwb_rd),
    .memwb_data   (memwb_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .alu_in0      (alu_in0),
    .alu_in1      (alu_in1),
    .alu_ctrl     (alu_ctrl),
    .rd_addr      (rd_addr),
    .reg_write    (reg_write),
    .store_data   (store_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] rsd,
                       input logic [REG_AW-1:0] rt, input logic [DATA_W-1:0] rtd,
                       input logic src, input logic [DATA_W-1:0] im,
                       input logic [CTRL_W-1:0] op, input logic [REG_AW-1:0] rd);
    in_valid     = 1'b1;
    rs_addr      = rs;
    rs_data      = rsd;
    rt_addr      = rt;
    rt_data      = rtd;
    alu_src      = src;
    imm          = im;
    alu_ctrl_in  = op;
    rd_addr_in   = rd;
    reg_write_in = 1'b1;
  endtask

  task automatic no_fwd();
    exmem_wr = 1'b0; exmem_rd = '0; exmem_data = '0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    rs_addr = '0; rt_addr = '0; rs_data = '0; rt_data = '0; imm = '0;
    alu_src = 1'b0; alu_ctrl_in = '0; rd_addr_in = '0; reg_write_in = 1'b0;
    no_fwd();
    step(); step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in0", alu_in0, 32'd0);
    check("rst_regwr", 32'(reg_write), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // No hazard
    issue(5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 32'd0, ALU_ADD, 5'd8);
    step();
    in_valid = 1'b0;
    check("nh_valid", 32'(out_valid), 32'd1);
    check("nh_in0", alu_in0, 32'd5);
    check("nh_in1", alu_in1, 32'd7);
    check("nh_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    check("nh_rd", 32'(rd_addr), 32'd8);
    check("nh_regwr", 32'(reg_write), 32'd1);
    step();
    check("consumed_valid", 32'(out_valid), 32'd0);
    check("consumed_regwr", 32'(reg_write), 32'd0);

    // Double hazard: EX/MEM beats MEM/WB
    issue(5'd2, 32'd1, 5'd0, 32'd33, 1'b0, 32'd0, ALU_OR, 5'd9);
    exmem_wr = 1'b1; exmem_rd = 5'd2; exmem_data = 32'd11;
    memwb_wr = 1'b1; memwb_rd = 5'd2; memwb_data = 32'd22;
    step();
    check("dh_in0", alu_in0, 32'd11);
    check("dh_in1", alu_in1, 32'd33);
    // r0 never forwarded; rt gets MEM/WB
    issue(5'd0, 32'd44, 5'd5, 32'd6, 1'b0, 32'd0, ALU_AND, 5'd1);
    exmem_wr = 1'b1; exmem_rd = 5'd0; exmem_data = 32'd99;
    memwb_wr = 1'b1; memwb_rd = 5'd5; memwb_data = 32'd77;
    step();
    in_valid = 1'b0;
    no_fwd();
    check("r0_in0", alu_in0, 32'd44);
    check("mw_in1", alu_in1, 32'd77);
    step();

    // Hold with alu_src=0: rt operand refreshed from MEM/WB
    out_ready = 1'b0;
    issue(5'd6, 32'd100, 5'd7, 32'd200, 1'b0, 32'd0, ALU_SUB, 5'd10);
    step();
    in_valid = 1'b0;
    check("h0_in1_first", alu_in1, 32'd200);
    check("h0_in_ready", 32'(in_ready), 32'd0);
    memwb_wr = 1'b1; memwb_rd = 5'd7; memwb_data = 32'd9;
    step();
    check("h0_in1_fwd", alu_in1, 32'd9);
    check("h0_store", store_data, 32'd9);
    check("h0_in0", alu_in0, 32'd100);
    check("h0_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
    no_fwd();
    issue(5'd6, 32'd555, 5'd7, 32'd666, 1'b0, 32'd0, ALU_NOR, 5'd11);
    step();
    in_valid = 1'b0;
    check("h0_keep_in1", alu_in1, 32'd9);
    check("h0_nocap_in0", alu_in0, 32'd100);
    check("h0_nocap_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
    out_ready = 1'b1;
    step();
    check("h0_release", 32'(out_valid), 32'd0);

    // Hold with alu_src=1: immediate stays, store_data tracks rt
    out_ready = 1'b0;
    issue(5'd6, 32'd100, 5'd7, 32'd200, 1'b1, 32'h1234, ALU_ADD, 5'd12);
    step();
    in_valid = 1'b0;
    check("h1_in1_imm", alu_in1, 32'h1234);
    check("h1_store_first", store_data, 32'd200);
    memwb_wr = 1'b1; memwb_rd = 5'd7; memwb_data = 32'd9;
    step();
    no_fwd();
    check("h1_in1_keep", alu_in1, 32'h1234);
    check("h1_store_fwd", store_data, 32'd9);

    // Flush during hold
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    check("fh_valid", 32'(out_valid), 32'd0);
    check("fh_regwr", 32'(reg_write), 32'd0);

    // Flush beats simultaneous capture
    issue(5'd3, 32'd5, 5'd4, 32'd7, 1'b0, 32'd0, ALU_SLT, 5'd13);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fc_valid", 32'(out_valid), 32'd0);
    check("fc_regwr", 32'(reg_write), 32'd0);
    issue(5'd3, 32'd66, 5'd4, 32'd7, 1'b0, 32'd0, ALU_SLT, 5'd13);
    step();
    in_valid = 1'b0;
    check("fc_next_valid", 32'(out_valid), 32'd1);
    check("fc_next_in0", alu_in0, 32'd66);
    check("fc_next_ctrl", 32'(alu_ctrl), 32'(ALU_SLT));
    step();

    // Back-to-back
    for (int i = 0; i < 4; i++) begin
      issue(5'd3, 32'(1000 + i), 5'd4, 32'(2000 + i), 1'b0, 32'd0, ALU_ADD, 5'(i + 1));
      check($sformatf("b2b_in_ready%0d", i), 32'(in_ready), 32'd1);
      step();
      check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("b2b_in0_%0d", i), alu_in0, 32'(1000 + i));
      check($sformatf("b2b_rd%0d", i), 32'(rd_addr), 32'(i + 1));
    end
    in_valid = 1'b0;
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Reset mid-hold
    out_ready = 1'b0;
    issue(5'd3, 32'd123, 5'd4, 32'd7, 1'b0, 32'd0, ALU_ADD, 5'd14);
    step();
    in_valid = 1'b0;
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_in0", alu_in0, 32'd0);
    check("mr_regwr", 32'(reg_write), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("mr_after_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
